axis_frame_source: RTL and testbench

Descriptor-driven AXI4-Stream frame transmitter: each accepted descriptor (byte length, tid, tdest, tuser) produces one frame with a deterministic byte-count data pattern and a correct partial tkeep on the last beat. It is the sending end of the stream path whose receiving end is the team's AXI-stream frame FIFO. It serves as a traffic source for frame-FIFO bring-up, loopback self-test and link exercisers.

---
 rtl/axis_frame_source_pkg.sv | 31 +++
 rtl/axis_frame_source_if.sv | 50 +++++
 rtl/axis_frame_source_beat.sv | 35 +++
 rtl/axis_frame_source.sv | 178 +++++++++++++++++
 tb/tb_axis_frame_source.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_source_pkg.sv
// axis_frame_source_pkg
// Shared definitions for the descriptor-driven AXI4-Stream frame source:
//   - state_t    : transmitter FSM states (STATE_IDLE, STATE_SEND)
//   - keep_mask(): remaining-byte count -> contiguous LSB-first byte-enable mask
// The mask is built at MAX_KEEP_WIDTH bits; callers size-cast it down to
// their own KEEP_WIDTH, which keeps the function parameter-independent.
package axis_frame_source_pkg;

    typedef enum logic [0:0] {
        STATE_IDLE = 1'b0,
        STATE_SEND = 1'b1
    } state_t;

    localparam int unsigned MAX_KEEP_WIDTH = 128;

    // Low min(remaining, keep_width) bits set, all others clear.
    function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(
        input logic [31:0] remaining,
        input int unsigned keep_width
    );
        logic [MAX_KEEP_WIDTH-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_WIDTH; i++) begin
            if ((i < keep_width) && (i < remaining)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// axis_frame_source_if
// Bundles the descriptor input channel and the AXI4-Stream output channel
// of axis_frame_source. Signal names match the block's port names.
//   s_desc_len/tid/tdest/tuser/valid, s_desc_ready : descriptor handshake
//   m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser, m_axis_tready : stream
// Modports:
//   master : the frame source (consumes descriptors, drives the stream)
//   slave  : the environment (drives descriptors, consumes the stream)
interface axis_frame_source_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) ();

    logic [LEN_WIDTH-1:0]  s_desc_len;
    logic [ID_WIDTH-1:0]   s_desc_tid;
    logic [DEST_WIDTH-1:0] s_desc_tdest;
    logic [USER_WIDTH-1:0] s_desc_tuser;
    logic                  s_desc_valid;
    logic                  s_desc_ready;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [ID_WIDTH-1:0]   m_axis_tid;
    logic [DEST_WIDTH-1:0] m_axis_tdest;
    logic [USER_WIDTH-1:0] m_axis_tuser;

    modport master (
        input  s_desc_len, s_desc_tid, s_desc_tdest, s_desc_tuser, s_desc_valid,
        output s_desc_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tid, m_axis_tdest, m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        output s_desc_len, s_desc_tid, s_desc_tdest, s_desc_tuser, s_desc_valid,
        input  s_desc_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tid, m_axis_tdest, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_frame_source_beat.sv
// axis_frame_source_beat
// Combinational beat former: from the byte index of lane 0 and the bytes
// still to send (including this beat), produces the beat's data, byte
// enables and last flag.
//   byte_idx  in  8           pattern value carried by lane 0
//   remaining in  LEN_WIDTH   bytes left in the frame, this beat included
//   tdata     out DATA_WIDTH  lane k = (byte_idx + k) mod 256, 0 when disabled
//   tkeep     out KEEP_WIDTH  contiguous LSB-first enables
//   tlast     out 1           remaining fits in this beat
module axis_frame_source_beat
    import axis_frame_source_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [7:0]            byte_idx,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic [KEEP_WIDTH-1:0] tkeep,
    output logic                  tlast
);

    always_comb begin
        tkeep = KEEP_WIDTH'(keep_mask(32'(remaining), KEEP_WIDTH));
        tlast = (32'(remaining) <= 32'(KEEP_WIDTH));
        tdata = '0;
        for (int unsigned k = 0; k < KEEP_WIDTH; k++) begin
            if (tkeep[k]) begin
                tdata[8*k +: 8] = byte_idx + 8'(k);
            end
        end
    end

endmodule

// File: rtl/axis_frame_source.sv
// axis_frame_source
// Descriptor-driven AXI4-Stream frame transmitter. Each accepted descriptor
// yields one frame of ceil(len/KEEP_WIDTH) beats carrying a byte-count
// pattern, with a partial tkeep and tlast on the final beat. Zero-length
// descriptors are consumed and flagged on status_error without any beats.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bus (master)       descriptor channel in, AXI4-Stream channel out
//   status_busy        frame in progress
//   status_frame_done  one-cycle pulse after the last beat is accepted
//   status_error       one-cycle pulse after a zero-length descriptor
// Build option:
//   AXIS_FRAME_SOURCE_TUSER_EN  when defined, the last beat carries the
//   descriptor's tuser; otherwise m_axis_tuser is tied to zero.
// All stream outputs are registered; m_axis_tready only steers the register
// load enables.
module axis_frame_source
    import axis_frame_source_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    axis_frame_source_if.master bus,
    output logic                status_busy,
    output logic                status_frame_done,
    output logic                status_error
);

    state_t                state;
    logic [LEN_WIDTH-1:0]  rem_q;      // bytes left, current output beat included
    logic [7:0]            idx_q;      // pattern value of lane 0 of current beat

    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KEEP_WIDTH-1:0] tkeep_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [ID_WIDTH-1:0]   tid_q;
    logic [DEST_WIDTH-1:0] tdest_q;
    logic                  done_q;
    logic                  error_q;

    logic                  desc_ready;
    logic                  desc_fire;
    logic                  beat_fire;

    logic [LEN_WIDTH-1:0]  gen_rem;
    logic [7:0]            gen_idx;
    logic [DATA_WIDTH-1:0] gen_tdata;
    logic [KEEP_WIDTH-1:0] gen_tkeep;
    logic                  gen_tlast;

    assign desc_ready = (state == STATE_IDLE) && !rst;
    assign desc_fire  = bus.s_desc_valid && desc_ready;
    assign beat_fire  = tvalid_q && bus.m_axis_tready;

    // One beat former serves both the first beat (fresh descriptor) and
    // every following beat (counters advanced by one beat).
    always_comb begin
        if (state == STATE_IDLE) begin
            gen_rem = bus.s_desc_len;
            gen_idx = '0;
        end else begin
            gen_rem = rem_q - LEN_WIDTH'(KEEP_WIDTH);
            gen_idx = idx_q + 8'(KEEP_WIDTH);
        end
    end

    axis_frame_source_beat #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_beat (
        .byte_idx  (gen_idx),
        .remaining (gen_rem),
        .tdata     (gen_tdata),
        .tkeep     (gen_tkeep),
        .tlast     (gen_tlast)
    );

`ifdef AXIS_FRAME_SOURCE_TUSER_EN
    logic [USER_WIDTH-1:0] user_lat_q;
    logic [USER_WIDTH-1:0] tuser_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            user_lat_q <= '0;
            tuser_q    <= '0;
        end else if ((state == STATE_IDLE) && desc_fire) begin
            user_lat_q <= bus.s_desc_tuser;
            tuser_q    <= gen_tlast ? bus.s_desc_tuser : '0;
        end else if ((state == STATE_SEND) && beat_fire) begin
            tuser_q    <= (!tlast_q && gen_tlast) ? user_lat_q : '0;
        end
    end

    assign bus.m_axis_tuser = tuser_q;
`else
    logic unused_tuser;
    assign unused_tuser     = ^bus.s_desc_tuser;
    assign bus.m_axis_tuser = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STATE_IDLE;
            rem_q    <= '0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
            tdest_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (desc_fire) begin
                        tid_q   <= bus.s_desc_tid;
                        tdest_q <= bus.s_desc_tdest;
                        rem_q   <= bus.s_desc_len;
                        idx_q   <= '0;
                        if (bus.s_desc_len == '0) begin
                            error_q <= 1'b1;
                        end else begin
                            tvalid_q <= 1'b1;
                            tdata_q  <= gen_tdata;
                            tkeep_q  <= gen_tkeep;
                            tlast_q  <= gen_tlast;
                            state    <= STATE_SEND;
                        end
                    end
                end
                STATE_SEND: begin
                    if (beat_fire) begin
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tkeep_q  <= '0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= STATE_IDLE;
                        end else begin
                            rem_q   <= gen_rem;
                            idx_q   <= gen_idx;
                            tdata_q <= gen_tdata;
                            tkeep_q <= gen_tkeep;
                            tlast_q <= gen_tlast;
                        end
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    assign bus.s_desc_ready  = desc_ready;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tkeep  = tkeep_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tid    = tid_q;
    assign bus.m_axis_tdest  = tdest_q;

    assign status_busy       = (state == STATE_SEND);
    assign status_frame_done = done_q;
    assign status_error      = error_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// tb_axis_frame_source
// Directed bench for axis_frame_source: a 32-bit instance exercises frame
// shapes, back-pressure, zero-length descriptors, mid-frame reset and tuser;
// an 8-bit instance covers byte-index wrap over a 300-byte frame.
// Expected beats come from a reference pattern model queued per descriptor.
// Honors AXIS_FRAME_SOURCE_TUSER_EN when computing expected tuser.
`timescale 1ns/1ps
module tb_axis_frame_source;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic [7:0]  tid;
        logic [7:0]  tdest;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    beat_t qa[$];
    beat_t qb[$];

    logic busy_a, done_a, err_a;
    logic busy_b, done_b, err_b;

    axis_frame_source_if #(.DATA_WIDTH(32)) ifa ();
    axis_frame_source_if #(.DATA_WIDTH(8))  ifb ();

    axis_frame_source #(.DATA_WIDTH(32)) dut_a (
        .clk               (clk),
        .rst               (rst),
        .bus               (ifa.master),
        .status_busy       (busy_a),
        .status_frame_done (done_a),
        .status_error      (err_a)
    );

    axis_frame_source #(.DATA_WIDTH(8)) dut_b (
        .clk               (clk),
        .rst               (rst),
        .bus               (ifb.master),
        .status_busy       (busy_b),
        .status_frame_done (done_b),
        .status_error      (err_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pattern model: one entry per beat, kw bytes per beat.
    task automatic push_frame(input bit to_b, input int unsigned len,
                              input logic [7:0] tid, input logic [7:0] tdest,
                              input logic tuser);
        int unsigned kw;
        int unsigned rem;
        int unsigned idx;
        beat_t b;
        kw  = to_b ? 1 : 4;
        rem = len;
        idx = 0;
        while (rem > 0) begin
            b.data = '0;
            b.keep = '0;
            for (int unsigned k = 0; k < kw; k++) begin
                if (k < rem) begin
                    b.data[8*k +: 8] = 8'((idx + k) % 256);
                    b.keep[k] = 1'b1;
                end
            end
            b.last = (rem <= kw);
`ifdef AXIS_FRAME_SOURCE_TUSER_EN
            b.user = b.last ? tuser : 1'b0;
`else
            b.user = 1'b0;
`endif
            b.tid   = tid;
            b.tdest = tdest;
            if (to_b) qb.push_back(b);
            else      qa.push_back(b);
            rem = (rem > kw) ? rem - kw : 0;
            idx = (idx + kw) % 256;
        end
    endtask

    // ---------------- stream monitor, 32-bit instance ----------------
    logic        done_exp_a = 1'b0;
    logic        stall_a = 1'b0;
    logic [31:0] hold_data_a;
    logic [3:0]  hold_keep_a;
    logic        hold_last_a;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            done_exp_a = 1'b0;
            stall_a    = 1'b0;
        end else begin
            check("a_frame_done", done_a, done_exp_a);
            if (done_exp_a) check("a_ready_after_frame", ifa.s_desc_ready, 1);
            if (stall_a) begin
                check("a_hold_valid", ifa.m_axis_tvalid, 1);
                check("a_hold_data", ifa.m_axis_tdata, hold_data_a);
                check("a_hold_keep", ifa.m_axis_tkeep, hold_keep_a);
                check("a_hold_last", ifa.m_axis_tlast, hold_last_a);
            end
            done_exp_a  = 1'b0;
            stall_a     = ifa.m_axis_tvalid && !ifa.m_axis_tready;
            hold_data_a = ifa.m_axis_tdata;
            hold_keep_a = ifa.m_axis_tkeep;
            hold_last_a = ifa.m_axis_tlast;
            if (ifa.m_axis_tvalid && ifa.m_axis_tready) begin
                tests++;
                assert (qa.size() != 0) else begin
                    fails++;
                    $error("FAIL a_unexpected_beat: observed beat %0h expected none", ifa.m_axis_tdata);
                end
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("a_tdata", ifa.m_axis_tdata, e.data);
                    check("a_tkeep", ifa.m_axis_tkeep, e.keep);
                    check("a_tlast", ifa.m_axis_tlast, e.last);
                    check("a_tuser", ifa.m_axis_tuser, e.user);
                    check("a_tid",   ifa.m_axis_tid,   e.tid);
                    check("a_tdest", ifa.m_axis_tdest, e.tdest);
                    done_exp_a = e.last;
                end
            end
        end
    end

    // ---------------- stream monitor, 8-bit instance ----------------
    int unsigned acc_b = 0;
    logic        done_exp_b = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            done_exp_b = 1'b0;
        end else begin
            check("b_frame_done", done_b, done_exp_b);
            done_exp_b = 1'b0;
            if (ifb.m_axis_tvalid && ifb.m_axis_tready) begin
                if (acc_b == 255) check("b_beat255", ifb.m_axis_tdata, 8'hFF);
                if (acc_b == 256) check("b_beat256_wrap", ifb.m_axis_tdata, 8'h00);
                if (acc_b == 299) begin
                    check("b_beat299", ifb.m_axis_tdata, 8'h2B);
                    check("b_beat299_last", ifb.m_axis_tlast, 1);
                end
                tests++;
                assert (qb.size() != 0) else begin
                    fails++;
                    $error("FAIL b_unexpected_beat: observed beat %0h expected none", ifb.m_axis_tdata);
                end
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("b_tdata", {24'h0, ifb.m_axis_tdata}, e.data);
                    check("b_tkeep", {3'b0, ifb.m_axis_tkeep}, e.keep);
                    check("b_tlast", ifb.m_axis_tlast, e.last);
                    check("b_tuser", ifb.m_axis_tuser, e.user);
                    check("b_tid",   ifb.m_axis_tid,   e.tid);
                    check("b_tdest", ifb.m_axis_tdest, e.tdest);
                    done_exp_b = e.last;
                end
                acc_b++;
            end
        end
    end

    // ---------------- descriptor / drain helpers ----------------
    // All called at posedge+1; return at posedge+1 of the acceptance edge.
    task automatic desc_a(input int unsigned len, input logic [7:0] tid,
                          input logic [7:0] tdest, input logic tuser);
        int n = 0;
        while (!ifa.s_desc_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_desc_ready_wait", ifa.s_desc_ready, 1);
        ifa.s_desc_len   = 16'(len);
        ifa.s_desc_tid   = tid;
        ifa.s_desc_tdest = tdest;
        ifa.s_desc_tuser = tuser;
        ifa.s_desc_valid = 1'b1;
        push_frame(1'b0, len, tid, tdest, tuser);
        @(posedge clk); #1;
        ifa.s_desc_valid = 1'b0;
    endtask

    task automatic desc_b(input int unsigned len, input logic [7:0] tid,
                          input logic [7:0] tdest, input logic tuser);
        int n = 0;
        while (!ifb.s_desc_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_desc_ready_wait", ifb.s_desc_ready, 1);
        ifb.s_desc_len   = 16'(len);
        ifb.s_desc_tid   = tid;
        ifb.s_desc_tdest = tdest;
        ifb.s_desc_tuser = tuser;
        ifb.s_desc_valid = 1'b1;
        push_frame(1'b1, len, tid, tdest, tuser);
        @(posedge clk); #1;
        ifb.s_desc_valid = 1'b0;
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while ((qa.size() != 0 || ifa.m_axis_tvalid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_drain_left", qa.size(), 0);
        check("a_drain_valid", ifa.m_axis_tvalid, 0);
        check("a_idle_busy", busy_a, 0);
    endtask

    task automatic drain_b(input int budget);
        int n = 0;
        while ((qb.size() != 0 || ifb.m_axis_tvalid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_drain_left", qb.size(), 0);
        check("b_drain_valid", ifb.m_axis_tvalid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit [5:0] pat;
        rst = 1'b1;
        ifa.s_desc_len = '0; ifa.s_desc_tid = '0; ifa.s_desc_tdest = '0;
        ifa.s_desc_tuser = '0; ifa.s_desc_valid = 1'b0; ifa.m_axis_tready = 1'b0;
        ifb.s_desc_len = '0; ifb.s_desc_tid = '0; ifb.s_desc_tdest = '0;
        ifb.s_desc_tuser = '0; ifb.s_desc_valid = 1'b0; ifb.m_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        // reset values
        check("rst_ready",  ifa.s_desc_ready, 0);
        check("rst_tvalid", ifa.m_axis_tvalid, 0);
        check("rst_tdata",  ifa.m_axis_tdata, 0);
        check("rst_tkeep",  ifa.m_axis_tkeep, 0);
        check("rst_tlast",  ifa.m_axis_tlast, 0);
        check("rst_tid",    ifa.m_axis_tid, 0);
        check("rst_tdest",  ifa.m_axis_tdest, 0);
        check("rst_tuser",  ifa.m_axis_tuser, 0);
        check("rst_busy",   busy_a, 0);
        check("rst_done",   done_a, 0);
        check("rst_error",  err_a, 0);
        check("rst_ready_b", ifb.s_desc_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", ifa.s_desc_ready, 1);
        @(posedge clk); #1;

        // len=10 with tready held high: three beats, partial last
        ifa.m_axis_tready = 1'b1;
        desc_a(10, 8'h11, 8'h22, 1'b1);
        check("s1_first_valid", ifa.m_axis_tvalid, 1);
        check("s1_busy", busy_a, 1);
        check("s1_ready_low", ifa.s_desc_ready, 0);
        drain_a(20);

        // len=16 under back-pressure pattern 1,0,0,1,0,1
        pat = 6'b101001;
        desc_a(16, 8'h33, 8'h44, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ifa.m_axis_tready = pat[i];
            @(posedge clk); #1;
        end
        ifa.m_axis_tready = 1'b1;
        drain_a(20);

        // zero-length descriptor, then len=4
        desc_a(0, 8'h55, 8'h56, 1'b1);
        check("s3_error_pulse", err_a, 1);
        check("s3_no_valid", ifa.m_axis_tvalid, 0);
        @(posedge clk); #1;
        check("s3_error_clear", err_a, 0);
        check("s3_still_no_valid", ifa.m_axis_tvalid, 0);
        desc_a(4, 8'h57, 8'h58, 1'b0);
        check("s3_len4_tdata", ifa.m_axis_tdata, 32'h03020100);
        drain_a(20);

        // 8-bit instance: 300-byte frame, index wrap
        desc_b(300, 8'h5A, 8'hA5, 1'b1);
        drain_b(400);
        check("b_beat_count", acc_b, 300);

        // reset after beat 2 of a len=20 frame
        ifa.m_axis_tready = 1'b1;
        desc_a(20, 8'h66, 8'h77, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete();
        check("s5_valid_after_rst", ifa.m_axis_tvalid, 0);
        check("s5_busy_after_rst", busy_a, 0);
        check("s5_tlast_after_rst", ifa.m_axis_tlast, 0);
        desc_a(4, 8'h68, 8'h69, 1'b0);
        check("s5_restart_tdata", ifa.m_axis_tdata, 32'h03020100);
        drain_a(20);

        // tuser marking on a three-beat frame
        desc_a(9, 8'h12, 8'h34, 1'b1);
        drain_a(20);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
